// File: rtl/s_term_loopback_probe_if.sv
// Byte-stream handshake between the loopback probe and the USB debug endpoint.
// Ports: m_data_o (byte), m_valid_o (byte valid), m_ready_i (sink ready).
interface s_term_loopback_probe_if;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;

    modport master (
        output m_data_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/s_term_loopback_probe.sv
// South-terminal loopback probe: synchronises the 53 north-going wires, snapshots
// them on trig_i and streams a framed byte sequence (HEADER + 7 data bytes).
// Ports: CLK, resetn (async, active-low); n1_beg, n2_beg, n2_begb, n4_beg,
// nn4_beg, co0 (fabric wires); trig_i, ovr_clr_i; m (stream master: m_data_o,
// m_valid_o, m_ready_i); busy_o; ovr_cnt_o (saturating dropped-trigger count).
// Option: `define S_TERM_PROBE_CRC_EN appends a CRC-8 (poly 0x07) 9th byte.
module s_term_loopback_probe #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic [3:0]                  n1_beg,
    input  logic [7:0]                  n2_beg,
    input  logic [7:0]                  n2_begb,
    input  logic [15:0]                 n4_beg,
    input  logic [15:0]                 nn4_beg,
    input  logic                        co0,
    input  logic                        trig_i,
    input  logic                        ovr_clr_i,
    s_term_loopback_probe_if.master     m,
    output logic                        busy_o,
    output logic [7:0]                  ovr_cnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] CRC  = 2'd3;

    logic [55:0] sb_in;
    logic [55:0] sync_q [SYNC_STAGES];
    logic [55:0] sb;
    logic [55:0] snap;
    logic [1:0]  state;
    logic [2:0]  idx;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        accept;
    logic        last_acc;
    logic        ovr_inc;

    assign sb_in = {3'b000, co0, nn4_beg, n4_beg, n2_begb, n2_beg, n1_beg};
    assign sb    = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sb_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign m.m_data_o  = data_q;
    assign m.m_valid_o = valid_q;
    assign busy_o      = (state != IDLE);
    assign accept      = valid_q && m.m_ready_i;

`ifdef S_TERM_PROBE_CRC_EN
    assign last_acc = accept && (state == CRC);
`else
    assign last_acc = accept && (state == DATA) && (idx == 3'd6);
`endif

    // The edge that finishes a frame is a legal restart point, not an overrun.
    assign ovr_inc = busy_o && trig_i && !last_acc;

`ifdef S_TERM_PROBE_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Header starts a fresh CRC; every accepted byte (the presented data_q) folds in.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            crc_q <= '0;
        end else if ((state == IDLE && trig_i) || (last_acc && trig_i)) begin
            crc_q <= '0;
        end else if (accept) begin
            crc_q <= crc8(crc_q, data_q);
        end
    end
`endif

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            idx     <= '0;
            snap    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig_i) begin
                        snap    <= sb;
                        state   <= HDR;
                        data_q  <= HEADER;
                        valid_q <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        state  <= DATA;
                        idx    <= 3'd0;
                        data_q <= snap[7:0];
                    end
                end
                DATA: begin
                    if (accept && idx != 3'd6) begin
                        idx    <= idx + 3'd1;
                        data_q <= snap[{idx + 3'd1, 3'b000} +: 8];
                    end
`ifdef S_TERM_PROBE_CRC_EN
                    if (accept && idx == 3'd6) begin
                        state  <= CRC;
                        data_q <= crc8(crc_q, data_q);
                    end
`endif
                end
                CRC: begin
                end
                default: begin
                end
            endcase

            // Frame end: either restart straight into a new header or drop to idle.
            if (last_acc) begin
                if (trig_i) begin
                    snap    <= sb;
                    state   <= HDR;
                    data_q  <= HEADER;
                    valid_q <= 1'b1;
                end else begin
                    state   <= IDLE;
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ovr_cnt_o <= '0;
        end else if (ovr_clr_i) begin
            ovr_cnt_o <= '0;
        end else if (ovr_inc && ovr_cnt_o != 8'hFF) begin
            ovr_cnt_o <= ovr_cnt_o + 8'd1;
        end
    end

endmodule
